fifo_ctrl_param: RTL and testbench

Parametrised synchronous FIFO controller that succeeds the fixed 128x8 UART FIFO. Width, depth and threshold are generic. All DEPTH locations are usable; full asserts at DEPTH, not DEPTH-1. Adds occupancy count, a read-data valid strobe, and sticky overflow/underflow error flags in place of simulation-only overflow checks. Storage is an inferred register/RAM array with no vendor primitive. It sits between the UART tx/rx datapaths and the APB register file.

---
 rtl/fifo_ctrl_param.sv | 119 +++++++++++
 tb/tb_fifo_ctrl_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO controller with occupancy count, registered read data
// with valid strobe, threshold status flags and sticky overflow/underflow error flags.
module fifo_ctrl_param #(
  parameter int WIDTH      = 8,
  parameter int ADDR_BITS  = 7,
  parameter int AEMPTY_LVL = 4,
  parameter int AFULL_LVL  = 124
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 write_n,
  input  logic                 read_n,
  input  logic [ADDR_BITS:0]   level,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 half,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C  = (ADDR_BITS + 1)'(AFULL_LVL);
  localparam logic [ADDR_BITS:0] AEMPTY_C = (ADDR_BITS + 1)'(AEMPTY_LVL);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_acc, wr_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign half         = (count_q >= level);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
  assign rd_acc = !read_n && !empty;
  assign wr_acc = !write_n && (!full || rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q && !clr_err;
    underflow_d  = underflow_q && !clr_err;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    end
    if (rd_acc) begin
      rd_ptr_d     = rd_ptr_q + ADDR_BITS'(1);
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_BITS + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_BITS + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error event wins over a coincident clear.
    if (!write_n && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (!read_n && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately not reset so it can map onto inferred RAM.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param: a queue-based reference model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_fifo_ctrl_param;

  localparam int DEPTH = 128;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       write_n = 1'b1;
  logic       read_n = 1'b1;
  logic [7:0] level = 8'd64;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] count;
  logic       full, empty, half, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_dv = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  fifo_ctrl_param dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .write_n      (write_n),
    .read_n       (read_n),
    .level        (level),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .half         (half),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  // Model: a plain queue; reads pop the oldest word before a write pushes the new one.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_dout = 8'h00;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      bit rd, wr, ovf_evt, udf_evt;
      rd      = !read_n && (m_q.size() > 0);
      wr      = !write_n && ((m_q.size() < DEPTH) || rd);
      ovf_evt = !write_n && !wr;
      udf_evt = !read_n && (m_q.size() == 0);
      m_dv    = rd;
      if (rd) m_dout = m_q.pop_front();
      if (wr) m_q.push_back(data_in);
      m_ovf = ovf_evt ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_udf = udf_evt ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    int n;
    n = m_q.size();
    checkOutput("model_count", 32'(count), 32'(n));
    checkOutput("model_full", 32'(full), 32'(n == DEPTH));
    checkOutput("model_empty", 32'(empty), 32'(n == 0));
    checkOutput("model_half", 32'(half), 32'(n >= int'(level)));
    checkOutput("model_afull", 32'(almost_full), 32'(n >= 124));
    checkOutput("model_aempty", 32'(almost_empty), 32'(n <= 4));
    checkOutput("model_ovf", 32'(overflow), 32'(m_ovf));
    checkOutput("model_udf", 32'(underflow), 32'(m_udf));
    checkOutput("model_dv", 32'(data_valid), 32'(m_dv));
    checkOutput("model_dout", 32'(data_out), 32'(m_dout));
  end

  // Drive one cycle of inputs from a negedge, return at the following negedge.
  task automatic applyStimulus(input logic wn, input logic rn, input logic [7:0] din,
                               input logic clr);
    write_n = wn;
    read_n  = rn;
    data_in = din;
    clr_err = clr;
    @(negedge clock);
    write_n = 1'b1;
    read_n  = 1'b1;
    clr_err = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_aempty", 32'(almost_empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_dout", 32'(data_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: fill to full, then overflow
    for (int i = 1; i <= 128; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 123) checkOutput("t1_afull_123", 32'(almost_full), 32'd0);
      if (i == 124) checkOutput("t1_afull_124", 32'(almost_full), 32'd1);
      if (i == 127) checkOutput("t1_full_127", 32'(full), 32'd0);
    end
    checkOutput("t1_count", 32'(count), 32'd128);
    checkOutput("t1_full", 32'(full), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
    checkOutput("t1_ovf", 32'(overflow), 32'd1);
    checkOutput("t1_count_ovf", 32'(count), 32'd128);

    // 2: drain in order
    for (int i = 1; i <= 128; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("t2_dout", 32'(data_out), 32'(i));
      checkOutput("t2_dv", 32'(data_valid), 32'd1);
    end
    checkOutput("t2_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    checkOutput("t2_clr_ovf", 32'(overflow), 32'd0);
    checkOutput("t2_dv_idle", 32'(data_valid), 32'd0);

    // 3: simultaneous read/write while full
    for (int i = 1; i <= 128; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hAA, 1'b0);
    checkOutput("t3_count", 32'(count), 32'd128);
    checkOutput("t3_dout", 32'(data_out), 32'h01);
    checkOutput("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 128; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_dout_last", 32'(data_out), 32'h80);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_dout_aa", 32'(data_out), 32'hAA);
    checkOutput("t3_empty", 32'(empty), 32'd1);

    // 4: simultaneous read/write while empty
    applyStimulus(1'b0, 1'b0, 8'h55, 1'b0);
    checkOutput("t4_count", 32'(count), 32'd1);
    checkOutput("t4_udf", 32'(underflow), 32'd1);
    checkOutput("t4_dv", 32'(data_valid), 32'd0);
    checkOutput("t4_dout_hold", 32'(data_out), 32'hAA);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("t4_dout", 32'(data_out), 32'h55);
    checkOutput("t4_udf_clr", 32'(underflow), 32'd0);

    // 5: runtime half threshold, clear colliding with overflow
    level = 8'd3;
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
    checkOutput("t5_half_2", 32'(half), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    checkOutput("t5_half_3", 32'(half), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_half_rd", 32'(half), 32'd0);
    checkOutput("t5_dout", 32'(data_out), 32'h11);
    for (int i = 0; i < 126; i++) applyStimulus(1'b0, 1'b1, 8'(i + 64), 1'b0);
    checkOutput("t5_full", 32'(full), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
    checkOutput("t5_ovf_setwins", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    checkOutput("t5_ovf_clr", 32'(overflow), 32'd0);

    // 6: async reset mid-cycle
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t6_ovf_pre", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("t6_underflow_pre", 32'(underflow), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_dout", 32'(data_out), 32'd0);
    checkOutput("t6_ovf", 32'(overflow), 32'd0);
    checkOutput("t6_udf", 32'(underflow), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t6_udf_after", 32'(underflow), 32'd1);
    checkOutput("t6_dv_after", 32'(data_valid), 32'd0);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
